// File: rtl/key_debounce_pulse.sv
// Multi-channel push-button conditioner: synchronises raw keys, rejects contact
// bounce with a per-key stability counter, and emits press/release pulses plus a level.
module key_debounce_pulse #(
  parameter int N          = 3,
  parameter int DELAY      = 240000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_pulse,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_state
);

  localparam int           CW   = $clog2(DELAY);
  localparam logic [CW-1:0] LAST = CW'(DELAY - 1);
  localparam logic [N-1:0] IDLE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] p;

  // Synchronisers reset to the released board level so reset release never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign p = sync2 ^ IDLE;

  for (genvar i = 0; i < N; i++) begin : g_chan
    state_t        state;
    logic [CW-1:0] cnt;
    logic          pulse_r;
    logic          release_r;
    logic          level_r;

    // A level change is accepted only after DELAY+1 consecutive agreeing samples
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= RELEASED;
        cnt       <= '0;
        pulse_r   <= 1'b0;
        release_r <= 1'b0;
        level_r   <= 1'b0;
      end else begin
        pulse_r   <= 1'b0;
        release_r <= 1'b0;
        case (state)
          RELEASED: begin
            if (p[i]) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!p[i]) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state   <= PRESSED;
              cnt     <= '0;
              pulse_r <= 1'b1;
              level_r <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PRESSED: begin
            if (!p[i]) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (p[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state     <= RELEASED;
              cnt       <= '0;
              release_r <= 1'b1;
              level_r   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_pulse[i]   = pulse_r;
    assign key_release[i] = release_r;
    assign key_state[i]   = level_r;
  end

endmodule
